// File: rtl/clint_unit_pkg.sv
// rtl/clint_unit_pkg.sv - CLINT offsets, mcause codes, mip bit positions and FSM types
package clint_unit_pkg;

    localparam logic [15:0] OFF_MSIP        = 16'h0000;
    localparam logic [15:0] OFF_MTIMECMP_LO = 16'h4000;
    localparam logic [15:0] OFF_MTIMECMP_HI = 16'h4004;
    localparam logic [15:0] OFF_MTIME_LO    = 16'hBFF8;
    localparam logic [15:0] OFF_MTIME_HI    = 16'hBFFC;

    localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;
    localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
    localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;

    localparam int MIP_MEIP = 11;
    localparam int MIP_MTIP = 7;
    localparam int MIP_MSIP = 3;

    // Last hold_cnt value before HOLD returns to IDLE (three cycles in HOLD)
    localparam logic [1:0] HOLD_LAST = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_HOLD
    } clint_state_e;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_MEI,
        SRC_MSI,
        SRC_MTI
    } irq_src_e;

    function automatic logic [31:0] src_cause(input irq_src_e src);
        logic [31:0] cause;
        cause = 32'h0;
        case (src)
            SRC_MEI: cause = CAUSE_MEI;
            SRC_MSI: cause = CAUSE_MSI;
            SRC_MTI: cause = CAUSE_MTI;
            default: cause = 32'h0;
        endcase
        return cause;
    endfunction

endpackage

// File: rtl/mtime_counter.sv
// rtl/mtime_counter.sv - prescaled 64-bit mtime counter with half-word write ports
module mtime_counter #(
    parameter int TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] mtime
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc;
    logic          tick;

    assign tick = (presc == PRESC_MAX);

    // Prescaler free-runs 0..TICK_DIV-1; stores to mtime do not disturb it
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // A store to either half suppresses the increment; the other half is left as is
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime <= 64'h0;
        end else if (wr_lo || wr_hi) begin
            if (wr_lo) begin
                mtime[31:0] <= wdata;
            end
            if (wr_hi) begin
                mtime[63:32] <= wdata;
            end
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

endmodule

// File: rtl/clint_unit.sv
// rtl/clint_unit.sv - machine timer/software/external interrupt source and request FSM
module clint_unit
    import clint_unit_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int          TICK_DIV  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_we,
    input  logic        mem_re,
    output logic [31:0] mem_rdata,
    output logic        hit,
    input  logic        ext_irq,
    input  logic        mstatus_mie,
    input  logic [2:0]  mie_in,
    input  logic        irq_ack,
    output logic        interrupt,
    output logic [31:0] irq_cause,
    output logic [31:0] mip
);

    logic        in_win;
    logic [15:0] off;
    logic        sel_msip;
    logic        sel_cmp_lo;
    logic        sel_cmp_hi;
    logic        sel_time_lo;
    logic        sel_time_hi;

    logic        msip;
    logic [63:0] mtimecmp;
    logic [63:0] mtime;

    logic        meip_q;
    logic        mtip_q;
    logic        msip_q;

    logic        pend_mei;
    logic        pend_msi;
    logic        pend_mti;
    irq_src_e    top_src;
    irq_src_e    src;
    logic        src_live;

    clint_state_e state;
    logic [1:0]   hold_cnt;

    assign in_win = (mem_addr[31:16] == BASE_ADDR[31:16]);
    assign off    = mem_addr[15:0];

    // Word decode inside the 64 KiB window
    always_comb begin
        sel_msip    = in_win && (off == OFF_MSIP);
        sel_cmp_lo  = in_win && (off == OFF_MTIMECMP_LO);
        sel_cmp_hi  = in_win && (off == OFF_MTIMECMP_HI);
        sel_time_lo = in_win && (off == OFF_MTIME_LO);
        sel_time_hi = in_win && (off == OFF_MTIME_HI);
    end

    assign hit = sel_msip | sel_cmp_lo | sel_cmp_hi | sel_time_lo | sel_time_hi;

    mtime_counter #(
        .TICK_DIV (TICK_DIV)
    ) u_mtime (
        .clk   (clk),
        .rst   (rst),
        .wr_lo (mem_we && sel_time_lo),
        .wr_hi (mem_we && sel_time_hi),
        .wdata (mem_wdata),
        .mtime (mtime)
    );

    // Load data straight from the current registers, zero when not a mapped load
    always_comb begin
        mem_rdata = 32'h0;
        if (mem_re) begin
            if (sel_msip)    mem_rdata = {31'h0, msip};
            if (sel_cmp_lo)  mem_rdata = mtimecmp[31:0];
            if (sel_cmp_hi)  mem_rdata = mtimecmp[63:32];
            if (sel_time_lo) mem_rdata = mtime[31:0];
            if (sel_time_hi) mem_rdata = mtime[63:32];
        end
    end

    // Store-written msip and mtimecmp registers
    always_ff @(posedge clk) begin
        if (rst) begin
            msip     <= 1'b0;
            mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else if (mem_we) begin
            if (sel_msip)   msip            <= mem_wdata[0];
            if (sel_cmp_lo) mtimecmp[31:0]  <= mem_wdata;
            if (sel_cmp_hi) mtimecmp[63:32] <= mem_wdata;
        end
    end

    // Pending bits sampled every cycle; the FSM only sees these registered copies
    always_ff @(posedge clk) begin
        if (rst) begin
            meip_q <= 1'b0;
            mtip_q <= 1'b0;
            msip_q <= 1'b0;
        end else begin
            meip_q <= ext_irq;
            mtip_q <= (mtime >= mtimecmp);
            msip_q <= msip;
        end
    end

    always_comb begin
        mip           = 32'h0;
        mip[MIP_MEIP] = meip_q;
        mip[MIP_MTIP] = mtip_q;
        mip[MIP_MSIP] = msip_q;
    end

    // Enabled sources, fixed priority MEI > MSI > MTI, and liveness of the latched one
    always_comb begin
        pend_mei = meip_q & mie_in[2];
        pend_mti = mtip_q & mie_in[1];
        pend_msi = msip_q & mie_in[0];
        if (pend_mei)      top_src = SRC_MEI;
        else if (pend_msi) top_src = SRC_MSI;
        else if (pend_mti) top_src = SRC_MTI;
        else               top_src = SRC_NONE;
        case (src)
            SRC_MEI: src_live = pend_mei;
            SRC_MSI: src_live = pend_msi;
            SRC_MTI: src_live = pend_mti;
            default: src_live = 1'b0;
        endcase
    end

    // Request FSM: raise, hold until ack or withdrawal, then a short HOLD while MIE is cleared
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            interrupt <= 1'b0;
            irq_cause <= 32'h0;
            src       <= SRC_NONE;
            hold_cnt  <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mstatus_mie && (top_src != SRC_NONE)) begin
                        state     <= ST_REQ;
                        interrupt <= 1'b1;
                        src       <= top_src;
                        irq_cause <= src_cause(top_src);
                    end
                end
                ST_REQ: begin
                    if (irq_ack) begin
                        state     <= ST_HOLD;
                        interrupt <= 1'b0;
                        hold_cnt  <= 2'd0;
                    end else if (!mstatus_mie || !src_live) begin
                        state     <= ST_IDLE;
                        interrupt <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!mstatus_mie || (hold_cnt == HOLD_LAST)) begin
                        state <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 2'd1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    interrupt <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clint_unit.sv
// tb/tb_clint_unit.sv - self-checking bench for clint_unit
module tb_clint_unit;

    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        clk;
    logic        rst;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        hit;
    logic        ext_irq;
    logic        mstatus_mie;
    logic [2:0]  mie_in;
    logic        irq_ack;
    logic        interrupt;
    logic [31:0] irq_cause;
    logic [31:0] mip;

    logic [31:0] rdata4;
    logic        hit4;
    logic        int4;
    logic [31:0] cause4;
    logic [31:0] mip4;

    int n_checks = 0;
    int n_err    = 0;

    logic [63:0] m_time;
    logic [63:0] m_cmp;
    logic        m_msip;
    logic [31:0] m_mip;

    clint_unit #(.BASE_ADDR(BASE), .TICK_DIV(1)) dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata), .hit(hit),
        .ext_irq(ext_irq), .mstatus_mie(mstatus_mie), .mie_in(mie_in),
        .irq_ack(irq_ack), .interrupt(interrupt), .irq_cause(irq_cause), .mip(mip)
    );

    clint_unit #(.BASE_ADDR(BASE), .TICK_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(rdata4), .hit(hit4),
        .ext_irq(ext_irq), .mstatus_mie(mstatus_mie), .mie_in(mie_in),
        .irq_ack(irq_ack), .interrupt(int4), .irq_cause(cause4), .mip(mip4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge; the reference model advances from the pre-edge inputs
    task automatic cyc();
        logic [63:0] nt;
        logic [63:0] ncmp;
        logic        nmsip;
        logic [31:0] nmip;
        nmip = 32'h0;
        if (ext_irq)         nmip[11] = 1'b1;
        if (m_time >= m_cmp) nmip[7]  = 1'b1;
        if (m_msip)          nmip[3]  = 1'b1;
        nt    = m_time + 64'd1;
        ncmp  = m_cmp;
        nmsip = m_msip;
        if (mem_we && (mem_addr[31:16] == BASE[31:16])) begin
            case (mem_addr[15:0])
                16'h0000: nmsip = mem_wdata[0];
                16'h4000: ncmp[31:0] = mem_wdata;
                16'h4004: ncmp[63:32] = mem_wdata;
                16'hBFF8: nt = {m_time[63:32], mem_wdata};
                16'hBFFC: nt = {mem_wdata, m_time[31:0]};
                default: ;
            endcase
        end
        if (rst) begin
            nt    = 64'h0;
            ncmp  = '1;
            nmsip = 1'b0;
            nmip  = 32'h0;
        end
        @(posedge clk);
        #1;
        m_time = nt;
        m_cmp  = ncmp;
        m_msip = nmsip;
        m_mip  = nmip;
    endtask

    task automatic wr(input logic [15:0] off, input logic [31:0] data);
        mem_addr  = BASE + {16'h0, off};
        mem_wdata = data;
        mem_we    = 1'b1;
        cyc();
        mem_we    = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data, output logic h);
        mem_addr = addr;
        mem_re   = 1'b1;
        #1;
        data     = mem_rdata;
        h        = hit;
        mem_re   = 1'b0;
    endtask

    task automatic chk_model(input string tag);
        logic [31:0] d;
        logic        h;
        rd(BASE + 32'h0000, d, h); chk({tag, "_msip"}, d, {31'h0, m_msip});
        rd(BASE + 32'h4000, d, h); chk({tag, "_cmp_lo"}, d, m_cmp[31:0]);
        rd(BASE + 32'h4004, d, h); chk({tag, "_cmp_hi"}, d, m_cmp[63:32]);
        rd(BASE + 32'hBFF8, d, h); chk({tag, "_time_lo"}, d, m_time[31:0]);
        rd(BASE + 32'hBFFC, d, h); chk({tag, "_time_hi"}, d, m_time[63:32]);
        chk({tag, "_mip"}, mip, m_mip);
    endtask

    initial begin
        logic [31:0] d;
        logic        h;
        rst = 1'b1; mem_addr = 32'h0; mem_wdata = 32'h0; mem_we = 1'b0; mem_re = 1'b0;
        ext_irq = 1'b0; mstatus_mie = 1'b0; mie_in = 3'b000; irq_ack = 1'b0;
        m_time = 64'h0; m_cmp = '1; m_msip = 1'b0; m_mip = 32'h0;

        // Reset state
        cyc(); cyc();
        chk("reset_interrupt", interrupt, 0);
        chk("reset_cause", irq_cause, 0);
        chk("reset_mip", mip, 0);
        chk("reset_hit", hit, 0);
        chk("reset_rdata", mem_rdata, 0);
        chk("reset_dut4_irq", int4, 0);
        chk("reset_dut4_cause", cause4, 0);
        chk("reset_dut4_mip", mip4, 0);
        chk("reset_dut4_hit", hit4, 0);
        rd(BASE + 32'hBFF8, d, h); chk("reset_mtime_lo", d, 0); chk("reset_hit_mtime", h, 1);
        rd(BASE + 32'h4000, d, h); chk("reset_cmp_lo", d, 32'hFFFF_FFFF);
        rd(BASE + 32'h4004, d, h); chk("reset_cmp_hi", d, 32'hFFFF_FFFF);
        rst = 1'b0;

        // mtime rate with TICK_DIV=1 and TICK_DIV=4
        for (int n = 1; n <= 12; n++) begin
            cyc();
            mem_addr = BASE + 32'hBFF8;
            mem_re   = 1'b1;
            #1;
            chk("mtime_div1", mem_rdata, m_time[31:0]);
            chk("mtime_div4", rdata4, 64'(n / 4));
            mem_re   = 1'b0;
        end

        // Timer interrupt: interrupt two edges after mtime reaches mtimecmp
        mie_in = 3'b010; mstatus_mie = 1'b1;
        wr(16'h4004, 32'h0);
        wr(16'h4000, 32'd20);
        for (int i = 0; i < 64 && m_time != 64'd20; i++) begin
            cyc();
            chk("mti_not_early", interrupt, 0);
        end
        rd(BASE + 32'hBFF8, d, h); chk("mtime_at_cmp", d, 20);
        chk("mti_edge_k", interrupt, 0);
        cyc();
        chk("mtip_set", mip, m_mip);
        chk("mtip_bit", mip[7], 1);
        chk("mti_edge_k1", interrupt, 0);
        cyc();
        chk("mti_edge_k2", interrupt, 1);
        chk("mti_cause", irq_cause, 32'h8000_0007);
        irq_ack = 1'b1; mstatus_mie = 1'b0;
        cyc();
        irq_ack = 1'b0;
        chk("ack_drop", interrupt, 0);
        cyc();
        chk("hold_exit_mie0", interrupt, 0);
        chk("cause_kept", irq_cause, 32'h8000_0007);
        mstatus_mie = 1'b1;
        cyc();
        chk("rerequest_from_idle", interrupt, 1);

        // Raising mtimecmp withdraws the timer request without ack
        wr(16'h4000, 32'hFFFF_FFFF);
        chk("withdraw_e0", interrupt, 1);
        wr(16'h4004, 32'hFFFF_FFFF);
        chk("mtip_clear", mip, m_mip);
        chk("withdraw_e1", interrupt, 1);
        cyc();
        chk("withdraw_no_ack", interrupt, 0);
        chk("withdraw_cause_kept", irq_cause, 32'h8000_0007);

        // MEI beats MSI; after ack, MSI follows
        mie_in = 3'b111; ext_irq = 1'b1;
        wr(16'h0000, 32'h1);
        chk("meip_first", mip, m_mip);
        chk("mei_edge_k", interrupt, 0);
        cyc();
        chk("mei_req", interrupt, 1);
        chk("mei_cause", irq_cause, 32'h8000_000B);
        irq_ack = 1'b1; mstatus_mie = 1'b0; ext_irq = 1'b0;
        cyc();
        irq_ack = 1'b0;
        chk("mei_ack", interrupt, 0);
        cyc();
        mstatus_mie = 1'b1;
        cyc();
        chk("msi_req", interrupt, 1);
        chk("msi_cause", irq_cause, 32'h8000_0003);

        // msip store and ack in one cycle; HOLD lasts three cycles with MIE kept on
        irq_ack = 1'b1; ext_irq = 1'b1;
        wr(16'h0000, 32'h0);
        irq_ack = 1'b0;
        chk("msi_ack_store", interrupt, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("hold_three", interrupt, 0);
            chk("hold_mip", mip, m_mip);
        end
        chk("msip_cleared", mip[3], 0);
        cyc();
        chk("hold_then_mei", interrupt, 1);
        chk("hold_then_mei_cause", irq_cause, 32'h8000_000B);

        // Ack arriving with the withdrawal still goes to HOLD
        ext_irq = 1'b0;
        cyc();
        chk("withdraw_pending", interrupt, 1);
        irq_ack = 1'b1;
        cyc();
        irq_ack = 1'b0;
        chk("ack_wins_drop", interrupt, 0);
        ext_irq = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("ack_wins_hold", interrupt, 0);
        end
        cyc();
        chk("ack_wins_rereq", interrupt, 1);

        // Reset mid-request
        rst = 1'b1;
        cyc();
        chk("rst_mid_irq", interrupt, 0);
        chk("rst_mid_cause", irq_cause, 0);
        chk("rst_mid_mip", mip, 0);
        chk_model("rst_mid");
        rst = 1'b0; ext_irq = 1'b0; mstatus_mie = 1'b0; mie_in = 3'b000;

        // Unmapped offsets
        mem_addr = BASE + 32'h8000; mem_re = 1'b1;
        #1;
        chk("unmapped_hit", hit, 0);
        chk("unmapped_rdata", mem_rdata, 0);
        mem_re = 1'b0;
        wr(16'h8000, 32'h1234_5678);
        chk_model("unmapped_write");
        rd(32'h0300_4000, d, h);
        chk("outside_hit", h, 0);
        chk("outside_rdata", d, 0);

        // Low-half carry, no carry on half writes, and 64-bit wrap
        wr(16'hBFFC, 32'h0);
        wr(16'hBFF8, 32'hFFFF_FFFF);
        cyc();
        rd(BASE + 32'hBFF8, d, h); chk("carry_lo", d, 0);
        rd(BASE + 32'hBFFC, d, h); chk("carry_hi", d, 1);
        wr(16'hBFFC, 32'hFFFF_FFFF);
        rd(BASE + 32'hBFF8, d, h); chk("no_carry_lo", d, 0);
        wr(16'hBFF8, 32'hFFFF_FFFF);
        cyc();
        rd(BASE + 32'hBFF8, d, h); chk("wrap_lo", d, 0);
        rd(BASE + 32'hBFFC, d, h); chk("wrap_hi", d, 0);

        // Randomized register traffic against the reference model
        for (int it = 0; it < 300; it++) begin
            logic [31:0] rv;
            logic [15:0] offs[5];
            logic [15:0] bad[4];
            int          sel;
            offs = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC};
            bad  = '{16'h8000, 16'h0004, 16'h4008, 16'hBFF4};
            case ($urandom_range(0, 3))
                0:       rv = 32'h0;
                1:       rv = 32'h1;
                2:       rv = 32'hFFFF_FFFF;
                default: rv = $urandom;
            endcase
            ext_irq = 1'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 9));
            if (sel < 5) begin
                wr(offs[sel], rv);
            end else if (sel == 5) begin
                sel = int'($urandom_range(0, 3));
                mem_addr = BASE + {16'h0, bad[sel]};
                #1;
                chk("rand_unmapped_hit", hit, 0);
                wr(bad[sel], rv);
            end else begin
                cyc();
            end
            chk("rand_mip", mip, m_mip);
            sel = int'($urandom_range(0, 4));
            rd(BASE + {16'h0, offs[sel]}, d, h);
            chk("rand_hit", h, 1);
            case (sel)
                0:       chk("rand_msip", d, {31'h0, m_msip});
                1:       chk("rand_cmp_lo", d, m_cmp[31:0]);
                2:       chk("rand_cmp_hi", d, m_cmp[63:32]);
                3:       chk("rand_time_lo", d, m_time[31:0]);
                default: chk("rand_time_hi", d, m_time[63:32]);
            endcase
        end
        chk("rand_no_irq", interrupt, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
